// File: rtl/dbg_harness_ctrl.sv
// dbg_harness_ctrl: run control and shared-memory harness between a debug port and an accelerator.
//   Parameters: DATA_W word width, ADDR_W address width (DEPTH = 2**ADDR_W), CYC_W cycle counter width.
//   Run control : run (rising edge starts), done_i -> dut_start, busy, done, timeout, cycles.
//   Accel port  : dut_addr, dut_wdata, dut_we -> dut_rdata (owns memory in START/RUN).
//   Debug port  : dbg_req, dbg_we, dbg_addr, dbg_wdata -> dbg_ack, dbg_rdata (owns memory in IDLE/DONE).
//   clk rising edge; rstn synchronous active-low. All outputs registered; memory is not reset.
module dbg_harness_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int CYC_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              run,
    input  logic              done_i,
    output logic              dut_start,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CYC_W-1:0]  cycles,
    input  logic [ADDR_W-1:0] dut_addr,
    input  logic [DATA_W-1:0] dut_wdata,
    input  logic              dut_we,
    output logic [DATA_W-1:0] dut_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} run_st_t;
    typedef enum logic [1:0] {D_IDLE, D_ACK, D_WAIT} dbg_st_t;

    logic [DATA_W-1:0] mem [DEPTH];

    run_st_t           state_q, state_d;
    dbg_st_t           dstate_q, dstate_d;
    logic              run_q;
    logic              dut_start_q, dut_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic [CYC_W-1:0]  cycles_q, cycles_d;
    logic [DATA_W-1:0] dut_rdata_q, dut_rdata_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              run_rise, mem_free, dbg_acc;

    always_comb begin
        run_rise  = run & ~run_q;
        mem_free  = (state_q == IDLE) || (state_q == DONE);
        // a run start in the same cycle beats a pending debug request
        dbg_acc   = (dstate_q == D_IDLE) && dbg_req && mem_free && !run_rise;
        state_d   = state_q;
        cycles_d  = cycles_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE, DONE: if (run_rise) begin
                state_d   = START;
                cycles_d  = '0;
                done_d    = 1'b0;
                timeout_d = 1'b0;
            end
            START: state_d = RUN;
            RUN: if (done_i) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else if (cycles_q == '1) begin
                state_d   = DONE;
                done_d    = 1'b1;
                timeout_d = 1'b1;
            end else begin
                cycles_d = cycles_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // status flops are loaded from the next state so they line up with it
        dut_start_d = state_d == START;
        busy_d      = (state_d == START) || (state_d == RUN);
        dut_rdata_d = mem_free ? '0 : mem[dut_addr];
        dstate_d    = dstate_q;
        case (dstate_q)
            D_IDLE:  dstate_d = dbg_acc ? D_ACK : D_IDLE;
            D_ACK:   dstate_d = D_WAIT;
            D_WAIT:  dstate_d = dbg_req ? D_WAIT : D_IDLE;
            default: dstate_d = D_IDLE;
        endcase
        dbg_ack_d   = dstate_q == D_ACK;
        // old word captured at acceptance gives read-before-write on debug writes
        dbg_rdata_d = dbg_acc ? mem[dbg_addr] : dbg_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            dstate_q    <= D_IDLE;
            run_q       <= 1'b1;
            dut_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cycles_q    <= '0;
            dut_rdata_q <= '0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            dstate_q    <= dstate_d;
            run_q       <= run;
            dut_start_q <= dut_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            cycles_q    <= cycles_d;
            dut_rdata_q <= dut_rdata_d;
            dbg_ack_q   <= dbg_ack_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // ownership makes the two write ports mutually exclusive
    always_ff @(posedge clk) begin
        if (rstn && dbg_acc && dbg_we)
            mem[dbg_addr] <= dbg_wdata;
        else if (rstn && !mem_free && dut_we)
            mem[dut_addr] <= dut_wdata;
    end

    assign dut_start = dut_start_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign cycles    = cycles_q;
    assign dut_rdata = dut_rdata_q;
    assign dbg_ack   = dbg_ack_q;
    assign dbg_rdata = dbg_rdata_q;
endmodule

// File: tb/tb_dbg_harness_ctrl.sv
// tb_dbg_harness_ctrl: randomized scenario bench for dbg_harness_ctrl against a memory/run reference model.
module tb_dbg_harness_ctrl;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int CW = 4;
    localparam int DEPTH = 16;
    localparam int CMAX = 15;

    logic clk = 1'b0, rstn = 1'b0, run = 1'b0, done_i = 1'b0, dut_we = 1'b0;
    logic dbg_req = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] dut_addr = '0, dbg_addr = '0;
    logic [DW-1:0] dut_wdata = '0, dbg_wdata = '0;
    logic dut_start, busy, done, timeout, dbg_ack;
    logic [CW-1:0] cycles;
    logic [DW-1:0] dut_rdata, dbg_rdata;

    int n_chk = 0, n_fail = 0;
    logic [DW-1:0] mdl [DEPTH];

    dbg_harness_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CYC_W(CW)) dut (
        .clk(clk), .rstn(rstn), .run(run), .done_i(done_i),
        .dut_start(dut_start), .busy(busy), .done(done), .timeout(timeout), .cycles(cycles),
        .dut_addr(dut_addr), .dut_wdata(dut_wdata), .dut_we(dut_we), .dut_rdata(dut_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              output logic [DW-1:0] rd, output int lat);
        dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd; lat = 0; rd = 'x;
        while (lat < 50) begin
            tick;
            lat++;
            if (dbg_ack === 1'b1) break;
        end
        rd = dbg_rdata;
        dbg_req = 1'b0; dbg_we = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        rstn = 1'b0; run = 1'b1;
        tick; tick;
        n_chk++;
        if ({dut_start, busy, done, timeout, dbg_ack} !== 5'b0 || cycles !== '0 ||
            dut_rdata !== '0 || dbg_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_values: start=%b busy=%b done=%b to=%b ack=%b cyc=%0d rd=%h dbgrd=%h, required all 0",
                     dut_start, busy, done, timeout, dbg_ack, cycles, dut_rdata, dbg_rdata);
        end
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_chk++;
            if (busy !== 1'b0 || dut_start !== 1'b0) begin
                n_fail++;
                $display("FAIL run_held_through_reset: busy=%b start=%b, required 0 0", busy, dut_start);
            end
        end
        run = 1'b0;
        tick;
    endtask

    task automatic test_fill;
        logic [DW-1:0] rd, w;
        int lat;
        for (int a = 0; a < DEPTH; a++) begin
            w = $urandom;
            dbg_access(1'b1, AW'(a), w, rd, lat);
            mdl[a] = w;
            n_chk++;
            if (lat !== 2 || dbg_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_ack_timing addr %0d: latency=%0d ack_after=%b, required 2 0", a, lat, dbg_ack);
            end
        end
    endtask

    task automatic test_dbg_rw;
        logic [DW-1:0] rd, w;
        logic [AW-1:0] a;
        logic we;
        int lat;
        dbg_access(1'b1, 4'd5, 32'hDEADBEEF, rd, lat);
        n_chk++;
        if (rd !== mdl[5] || lat !== 2) begin
            n_fail++;
            $display("FAIL write_old_word: rdata=%h lat=%0d, required %h 2", rd, lat, mdl[5]);
        end
        mdl[5] = 32'hDEADBEEF;
        dbg_access(1'b0, 4'd5, 32'h0, rd, lat);
        n_chk++;
        if (rd !== 32'hDEADBEEF || lat !== 2) begin
            n_fail++;
            $display("FAIL read_back_5: rdata=%h lat=%0d, required deadbeef 2", rd, lat);
        end
        for (int i = 0; i < 8; i++) begin
            we = 1'($urandom); a = AW'($urandom); w = $urandom;
            dbg_access(we, a, w, rd, lat);
            n_chk++;
            if (rd !== mdl[a] || lat !== 2) begin
                n_fail++;
                $display("FAIL rand_dbg we=%b addr=%0d: rdata=%h lat=%0d, required %h 2", we, a, rd, lat, mdl[a]);
            end
            if (we) mdl[a] = w;
        end
    endtask

    task automatic test_readback;
        logic [DW-1:0] rd;
        int lat;
        for (int a = 0; a < DEPTH; a++) begin
            dbg_access(1'b0, AW'(a), '0, rd, lat);
            n_chk++;
            if (rd !== mdl[a]) begin
                n_fail++;
                $display("FAIL readback addr %0d: rdata=%h, required %h", a, rd, mdl[a]);
            end
        end
    endtask

    // mode 0: plain run; 1: debug write requested mid-RUN; 2: debug write requested with the run edge
    task automatic do_run(input int d, input int mode);
        logic [AW-1:0] ra;
        logic [DW-1:0] rw, exp_rd;
        int idx, busy_len, starts, acks, exp_c;
        bit prev_own, fin;
        ra = AW'($urandom); rw = $urandom;
        run = 1'b0; done_i = 1'b0;
        tick;
        run = 1'b1;
        if (mode == 2) begin dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = ra; dbg_wdata = rw; end
        idx = -1; busy_len = 0; starts = 0; acks = 0; prev_own = 0; fin = 0; exp_rd = '0;
        for (int n = 0; n < 60; n++) begin
            tick;
            if (dbg_ack === 1'b1) acks++;
            n_chk++;
            if (dut_rdata !== (prev_own ? exp_rd : '0)) begin
                n_fail++;
                $display("FAIL dut_rdata cyc %0d: got %h, required %h", n, dut_rdata, prev_own ? exp_rd : '0);
            end
            dut_addr = AW'($urandom); dut_wdata = $urandom; dut_we = 1'($urandom);
            prev_own = busy;
            if (busy) begin
                exp_rd = mdl[dut_addr];
                if (dut_we) mdl[dut_addr] = dut_wdata;
            end
            if (busy !== 1'b1) begin fin = 1; break; end
            busy_len++;
            if (dut_start) starts++; else idx++;
            exp_c = idx < 0 ? 0 : idx;
            n_chk++;
            if (cycles !== CW'(exp_c) || done !== 1'b0 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL in_run idx %0d: cycles=%0d done=%b to=%b, required %0d 0 0", idx, cycles, done, timeout, exp_c);
            end
            done_i = (idx == d);
            if (mode == 1 && idx == 2) begin dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = ra; dbg_wdata = rw; end
        end
        done_i = 1'b0;
        n_chk++;
        if (!fin) begin
            n_fail++;
            $display("FAIL run_timeout d=%0d: busy never dropped", d);
        end
        exp_c = d < CMAX ? d : CMAX;
        n_chk++;
        if (busy_len !== exp_c + 2 || starts !== 1 || cycles !== CW'(exp_c) || done !== 1'b1 ||
            timeout !== (d > CMAX) || dut_start !== 1'b0 || acks !== 0) begin
            n_fail++;
            $display("FAIL run_result d=%0d: busy_len=%0d starts=%0d cycles=%0d done=%b to=%b acks=%0d, required %0d 1 %0d 1 %b 0",
                     d, busy_len, starts, cycles, done, timeout, acks, exp_c + 2, exp_c, d > CMAX);
        end
        if (mode != 0) begin
            tick;
            dut_we = 1'b0;
            n_chk++;
            if (dbg_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_ack_early: ack=%b, required 0", dbg_ack);
            end
            tick;
            n_chk++;
            if (dbg_ack !== 1'b1 || dbg_rdata !== mdl[ra]) begin
                n_fail++;
                $display("FAIL stall_served mode %0d: ack=%b rdata=%h, required 1 %h", mode, dbg_ack, dbg_rdata, mdl[ra]);
            end
            mdl[ra] = rw;
            dbg_req = 1'b0; dbg_we = 1'b0;
            tick;
        end
        dut_we = 1'b0; run = 1'b0;
        tick;
    endtask

    task automatic test_normal_run;
        do_run(10, 0);
        do_run(0, 0);
        test_readback;
    endtask

    task automatic test_timeout;
        do_run(20, 0);
        do_run(CMAX, 0);
        do_run(3, 0);
        for (int i = 0; i < 4; i++) do_run(int'($urandom_range(0, 20)), 0);
    endtask

    task automatic test_stall;
        do_run(6, 1);
        test_readback;
    endtask

    task automatic test_tie;
        do_run(5, 2);
        test_readback;
    endtask

    task automatic test_held_req;
        logic [AW-1:0] a;
        int acks;
        logic [DW-1:0] seen;
        a = AW'($urandom); acks = 0; seen = 'x;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = a;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (dbg_ack === 1'b1) begin acks++; seen = dbg_rdata; end
        end
        dbg_req = 1'b0;
        tick;
        n_chk++;
        if (acks !== 1 || seen !== mdl[a]) begin
            n_fail++;
            $display("FAIL held_req: acks=%0d rdata=%h, required 1 %h", acks, seen, mdl[a]);
        end
    endtask

    task automatic test_reset_mid_run;
        run = 1'b0; dut_we = 1'b0;
        tick;
        run = 1'b1;
        for (int i = 0; i < 5; i++) tick;
        n_chk++;
        if (busy !== 1'b1 || cycles === '0) begin
            n_fail++;
            $display("FAIL pre_reset_run: busy=%b cycles=%0d, required 1 and nonzero", busy, cycles);
        end
        rstn = 1'b0;
        tick;
        n_chk++;
        if ({dut_start, busy, done, timeout, dbg_ack} !== 5'b0 || cycles !== '0 ||
            dut_rdata !== '0 || dbg_rdata !== '0) begin
            n_fail++;
            $display("FAIL mid_run_reset: start=%b busy=%b done=%b to=%b ack=%b cyc=%0d, required all 0",
                     dut_start, busy, done, timeout, dbg_ack, cycles);
        end
        rstn = 1'b1;
        tick; tick;
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL no_restart_after_reset: busy=%b, required 0", busy);
        end
        run = 1'b0;
        tick;
        test_readback;
        do_run(4, 0);
    endtask

    initial begin
        test_reset;
        test_fill;
        test_dbg_rw;
        test_normal_run;
        test_timeout;
        test_stall;
        test_tie;
        test_held_req;
        test_reset_mid_run;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
